// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - execute/memory/writeback bus for mem_stage_ctrl
// Groups the execute-stage handshake (e_*), the byte-lane memory port (mem_*)
// and the writeback handshake (w_*). The slave modport is the stage controller;
// the master modport is everything around it (execute, memory, writeback).
interface mem_stage_ctrl_if #(
    parameter int SIZE_LOG2 = 13
);
    logic                 e_valid;
    logic                 e_ready;
    logic                 e_load;
    logic                 e_store;
    logic [1:0]           e_size;
    logic                 e_signed;
    logic [31:0]          e_addr;
    logic [31:0]          e_wdata;
    logic [4:0]           e_rd;

    logic                 mem_we;
    logic [1:0]           mem_size;
    logic                 mem_signed;
    logic [SIZE_LOG2-1:0] mem_a;
    logic [31:0]          mem_wd;
    logic [31:0]          mem_rd;

    logic                 w_valid;
    logic                 w_ready;
    logic [4:0]           w_rd;
    logic [31:0]          w_data;
    logic                 w_regwrite;
    logic                 w_fault;

    modport slave (
        input  e_valid, e_load, e_store, e_size, e_signed, e_addr, e_wdata, e_rd,
        output e_ready,
        output mem_we, mem_size, mem_signed, mem_a, mem_wd,
        input  mem_rd,
        output w_valid, w_rd, w_data, w_regwrite, w_fault,
        input  w_ready
    );

    modport master (
        output e_valid, e_load, e_store, e_size, e_signed, e_addr, e_wdata, e_rd,
        input  e_ready,
        input  mem_we, mem_size, mem_signed, mem_a, mem_wd,
        output mem_rd,
        input  w_valid, w_rd, w_data, w_regwrite, w_fault,
        output w_ready
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - M-stage control between execute, byte-lane memory and writeback
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  synchronous kill of all in-flight state (highest priority)
//   bus    mem_stage_ctrl_if.slave: e_* op handshake in, mem_* RAM port out
//          (read data mem_rd one cycle after address), w_* result handshake out
module mem_stage_ctrl #(
    parameter int SIZE_LOG2 = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_stage_ctrl_if.slave   bus
);
    localparam logic [32:0] MEM_BYTES = 33'd1 << SIZE_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    // M register: the accepted op. It doubles as the memory-port register, so
    // mem_a/size/signed/wd stay frozen from ISSUE through LOAD and hold their
    // last values until the next op is accepted.
    logic                 r_m_load;
    logic                 r_m_store;
    logic [1:0]           r_m_size;
    logic                 r_m_signed;
    logic [31:0]          r_m_addr;
    logic [31:0]          r_m_wdata;
    logic [4:0]           r_m_rd;

    // Writeback output register
    logic [31:0]          r_w_data;
    logic [4:0]           r_w_rd;
    logic                 r_w_regwrite;
    logic                 r_w_fault;

    logic                 w_e_ready;
    logic                 w_accept;
    logic                 w_mem_we;
    logic                 w_is_mem;
    logic                 w_fault;
    logic [32:0]          w_nbytes;
    logic [32:0]          w_last;

    // Last byte touched, computed 33 bits wide so an access running past the
    // top of a 32-bit address cannot wrap around and look in range.
    always_comb begin
        w_nbytes = 33'd4;
        case (r_m_size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            default: w_nbytes = 33'd4;
        endcase
    end

    assign w_last   = {1'b0, r_m_addr} + w_nbytes - 33'd1;
    assign w_is_mem = r_m_load | r_m_store;
    assign w_fault  = w_is_mem & ((r_m_size == 2'b11) | (r_m_load & r_m_store) | (w_last >= MEM_BYTES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_e_ready = 1'b0;
        w_accept  = 1'b0;
        w_mem_we  = 1'b0;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_e_ready = 1'b1;
                    if (bus.e_valid) begin
                        w_accept = 1'b1;
                        w_next   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_mem_we = r_m_store & ~w_fault;
                    w_next   = (r_m_load & ~w_fault) ? S_LOAD : S_RESP;
                end
                S_LOAD: begin
                    w_next = S_RESP;
                end
                S_RESP: begin
                    if (bus.w_ready) begin
                        w_e_ready = 1'b1;
                        if (bus.e_valid) begin
                            w_accept = 1'b1;
                            w_next   = S_ISSUE;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_load     <= 1'b0;
            r_m_store    <= 1'b0;
            r_m_size     <= 2'b00;
            r_m_signed   <= 1'b0;
            r_m_addr     <= 32'd0;
            r_m_wdata    <= 32'd0;
            r_m_rd       <= 5'd0;
            r_w_data     <= 32'd0;
            r_w_rd       <= 5'd0;
            r_w_regwrite <= 1'b0;
            r_w_fault    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_load   <= bus.e_load;
                r_m_store  <= bus.e_store;
                r_m_size   <= bus.e_size;
                r_m_signed <= bus.e_signed;
                r_m_addr   <= bus.e_addr;
                r_m_wdata  <= bus.e_wdata;
                r_m_rd     <= bus.e_rd;
            end
            // The result register only changes in ISSUE/LOAD, so it is frozen
            // for the whole of RESP regardless of how long w_ready stays low.
            if (r_state == S_ISSUE && !flush) begin
                r_w_rd <= r_m_rd;
                if (w_fault) begin
                    r_w_data     <= 32'd0;
                    r_w_fault    <= 1'b1;
                    r_w_regwrite <= 1'b0;
                end else if (r_m_store) begin
                    r_w_data     <= 32'd0;
                    r_w_fault    <= 1'b0;
                    r_w_regwrite <= 1'b0;
                end else if (r_m_load) begin
                    r_w_fault    <= 1'b0;
                    r_w_regwrite <= (r_m_rd != 5'd0);
                end else begin
                    r_w_data     <= r_m_addr;
                    r_w_fault    <= 1'b0;
                    r_w_regwrite <= (r_m_rd != 5'd0);
                end
            end
            if (r_state == S_LOAD && !flush) begin
                r_w_data <= bus.mem_rd;
            end
        end
    end

    // e_ready is gated by rst so it reads 0 throughout reset, not just IDLE.
    assign bus.e_ready    = w_e_ready & rst;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_size   = r_m_size;
    assign bus.mem_signed = r_m_signed;
    assign bus.mem_a      = r_m_addr[SIZE_LOG2-1:0];
    assign bus.mem_wd     = r_m_wdata;
    assign bus.w_valid    = (r_state == S_RESP);
    assign bus.w_data     = r_w_data;
    assign bus.w_rd       = r_w_rd;
    assign bus.w_regwrite = r_w_regwrite;
    assign bus.w_fault    = r_w_fault;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_fail;
    int   we_count;

    logic [7:0] mem_bytes [0:8191];

    mem_stage_ctrl_if #(.SIZE_LOG2(13)) bus ();

    mem_stage_ctrl #(.SIZE_LOG2(13)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-lane synchronous RAM: little-endian, read data one cycle after address.
    function automatic logic [31:0] mem_read(input logic [12:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0]  b0, b1, b2, b3;
        logic [12:0] a1, a2, a3;
        a1 = a + 13'd1;
        a2 = a + 13'd2;
        a3 = a + 13'd3;
        b0 = mem_bytes[a];
        b1 = mem_bytes[a1];
        b2 = mem_bytes[a2];
        b3 = mem_bytes[a3];
        case (sz)
            2'b00:   return sg ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'b01:   return sg ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            we_count = we_count + 1;
            mem_bytes[bus.mem_a] <= bus.mem_wd[7:0];
            if (bus.mem_size != 2'b00) mem_bytes[bus.mem_a + 13'd1] <= bus.mem_wd[15:8];
            if (bus.mem_size == 2'b10) begin
                mem_bytes[bus.mem_a + 13'd2] <= bus.mem_wd[23:16];
                mem_bytes[bus.mem_a + 13'd3] <= bus.mem_wd[31:24];
            end
        end
        bus.mem_rd <= mem_read(bus.mem_a, bus.mem_size, bus.mem_signed);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bus.e_load   = ld;
        bus.e_store  = st;
        bus.e_size   = sz;
        bus.e_signed = sg;
        bus.e_addr   = a;
        bus.e_wdata  = wd;
        bus.e_rd     = rd;
        bus.e_valid  = 1'b1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++; if (bus.e_ready !== 1'b0) begin n_fail++; $display("FAIL rst_e_ready: got %b expected 0", bus.e_ready); end
        n_checks++; if (bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL rst_w_valid: got %b expected 0", bus.w_valid); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        n_checks++; if ({bus.w_regwrite, bus.w_fault, bus.w_rd, bus.w_data} !== 39'd0) begin n_fail++; $display("FAIL rst_w_outs: got %h expected 0", {bus.w_regwrite, bus.w_fault, bus.w_rd, bus.w_data}); end
        n_checks++; if ({bus.mem_a, bus.mem_size, bus.mem_signed, bus.mem_wd} !== 48'd0) begin n_fail++; $display("FAIL rst_mem_outs: got %h expected 0", {bus.mem_a, bus.mem_size, bus.mem_signed, bus.mem_wd}); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.e_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_e_ready: got %b expected 1", bus.e_ready); end
    endtask

    task automatic test_store_load();
        int base;
        base = we_count;
        step();
        offer(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3);
        #1;
        n_checks++; if (bus.e_ready !== 1'b1) begin n_fail++; $display("FAIL sw_e_ready: got %b expected 1", bus.e_ready); end
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_issue_we: got %b expected 1", bus.mem_we); end
        n_checks++; if (bus.mem_a !== 13'h10 || bus.mem_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_issue_addr: got %h/%h expected 0010/deadbeef", bus.mem_a, bus.mem_wd); end
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_regwrite !== 1'b0 || bus.w_fault !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got v%b rw%b f%b expected v1 rw0 f0", bus.w_valid, bus.w_regwrite, bus.w_fault); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL sw_resp_we: got %b expected 0", bus.mem_we); end
        offer(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 5'd7);
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_size !== 2'b00 || bus.mem_signed !== 1'b1 || bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL lb_issue: got we%b sz%b sg%b v%b expected we0 sz00 sg1 v0", bus.mem_we, bus.mem_size, bus.mem_signed, bus.w_valid); end
        step();
        n_checks++; if (bus.w_valid !== 1'b0 || bus.mem_a !== 13'h13) begin n_fail++; $display("FAIL lb_load: got v%b a%h expected v0 a0013", bus.w_valid, bus.mem_a); end
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_data: got v%b %h expected v1 ffffffde", bus.w_valid, bus.w_data); end
        n_checks++; if (bus.w_regwrite !== 1'b1 || bus.w_rd !== 5'd7) begin n_fail++; $display("FAIL lb_rd: got rw%b rd%0d expected rw1 rd7", bus.w_regwrite, bus.w_rd); end
        step();
        n_checks++; if (bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL lb_idle: got %b expected 0", bus.w_valid); end
        n_checks++; if (we_count - base !== 1) begin n_fail++; $display("FAIL sw_we_cycles: got %0d expected 1", we_count - base); end
    endtask

    task automatic test_fault();
        int base;
        base = we_count;
        offer(1'b0, 1'b1, 2'b01, 1'b0, 32'h1FFE, 32'h0000A5A5, 5'd0);
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_top_we: got %b expected 1", bus.mem_we); end
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_fault !== 1'b0) begin n_fail++; $display("FAIL sh_top_fault: got v%b f%b expected v1 f0", bus.w_valid, bus.w_fault); end
        step();
        n_checks++; if (we_count - base !== 1) begin n_fail++; $display("FAIL sh_top_we_cycles: got %0d expected 1", we_count - base); end
        base = we_count;
        offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h1FFD, 32'h0, 5'd8);
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_oob_we: got %b expected 0", bus.mem_we); end
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_fault !== 1'b1) begin n_fail++; $display("FAIL lw_oob_fault: got v%b f%b expected v1 f1", bus.w_valid, bus.w_fault); end
        n_checks++; if (bus.w_regwrite !== 1'b0 || bus.w_data !== 32'd0) begin n_fail++; $display("FAIL lw_oob_result: got rw%b %h expected rw0 0", bus.w_regwrite, bus.w_data); end
        step();
        offer(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, 5'd9);
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ldst_we: got %b expected 0", bus.mem_we); end
        step();
        n_checks++; if (bus.w_fault !== 1'b1 || bus.w_regwrite !== 1'b0) begin n_fail++; $display("FAIL ldst_fault: got f%b rw%b expected f1 rw0", bus.w_fault, bus.w_regwrite); end
        step();
        n_checks++; if (we_count - base !== 0) begin n_fail++; $display("FAIL fault_we_cycles: got %0d expected 0", we_count - base); end
    endtask

    task automatic test_alu();
        offer(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd0);
        step();
        bus.e_valid = 1'b0;
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'h1234 || bus.w_regwrite !== 1'b0) begin n_fail++; $display("FAIL alu_rd0: got v%b %h rw%b expected v1 1234 rw0", bus.w_valid, bus.w_data, bus.w_regwrite); end
        offer(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5);
        step();
        bus.e_valid = 1'b0;
        step();
        n_checks++; if (bus.w_regwrite !== 1'b1 || bus.w_rd !== 5'd5 || bus.w_data !== 32'h1234) begin n_fail++; $display("FAIL alu_rd5: got rw%b rd%0d %h expected rw1 rd5 1234", bus.w_regwrite, bus.w_rd, bus.w_data); end
        offer(1'b0, 1'b0, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd6);
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL alu_we: got %b expected 0", bus.mem_we); end
        step();
        n_checks++; if (bus.w_fault !== 1'b0 || bus.w_data !== 32'hFFFFFFFF || bus.w_regwrite !== 1'b1) begin n_fail++; $display("FAIL alu_nofault: got f%b %h rw%b expected f0 ffffffff rw1", bus.w_fault, bus.w_data, bus.w_regwrite); end
        step();
    endtask

    task automatic test_backpressure();
        bus.w_ready = 1'b0;
        offer(1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE, 32'h0, 5'd9);
        step();
        offer(1'b0, 1'b0, 2'b10, 1'b0, 32'hBEEF, 32'h0, 5'd4);
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'hCAFE || bus.w_rd !== 5'd9 || bus.w_regwrite !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v%b %h rd%0d rw%b expected v1 cafe rd9 rw1", i, bus.w_valid, bus.w_data, bus.w_rd, bus.w_regwrite); end
            n_checks++; if (bus.e_ready !== 1'b0) begin n_fail++; $display("FAIL stall_e_ready[%0d]: got %b expected 0", i, bus.e_ready); end
            step();
        end
        bus.w_ready = 1'b1;
        #1;
        n_checks++; if (bus.e_ready !== 1'b1) begin n_fail++; $display("FAIL release_e_ready: got %b expected 1", bus.e_ready); end
        step();
        bus.e_valid = 1'b0;
        n_checks++; if (bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL release_issue: got %b expected 0", bus.w_valid); end
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'hBEEF || bus.w_rd !== 5'd4) begin n_fail++; $display("FAIL release_next: got v%b %h rd%0d expected v1 beef rd4", bus.w_valid, bus.w_data, bus.w_rd); end
        step();
    endtask

    task automatic test_flush();
        int base;
        offer(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd0);
        step();
        bus.e_valid = 1'b0;
        step();
        step();
        base = we_count;
        offer(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h99999999, 5'd0);
        step();
        bus.e_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++; if (bus.mem_we !== 1'b0 || bus.e_ready !== 1'b0) begin n_fail++; $display("FAIL flush_issue: got we%b rdy%b expected we0 rdy0", bus.mem_we, bus.e_ready); end
        step();
        flush = 1'b0;
        n_checks++; if (bus.w_valid !== 1'b0 || we_count - base !== 0) begin n_fail++; $display("FAIL flush_no_write: got v%b writes%0d expected v0 writes0", bus.w_valid, we_count - base); end
        offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd2);
        step();
        bus.e_valid = 1'b0;
        step();
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'h11223344) begin n_fail++; $display("FAIL flush_prior_data: got v%b %h expected v1 11223344", bus.w_valid, bus.w_data); end
        bus.w_ready = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++; if (bus.e_ready !== 1'b0) begin n_fail++; $display("FAIL flush_resp_ready: got %b expected 0", bus.e_ready); end
        step();
        n_checks++; if (bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp_valid: got %b expected 0", bus.w_valid); end
        flush = 1'b0;
        bus.w_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd11);
        step();
        bus.e_valid = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.w_valid !== 1'b0 || bus.w_data !== 32'd0 || bus.w_rd !== 5'd0 || bus.e_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_w: got v%b %h rd%0d rdy%b expected all 0", bus.w_valid, bus.w_data, bus.w_rd, bus.e_ready); end
        n_checks++; if (bus.mem_a !== 13'd0 || bus.mem_size !== 2'b00 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem: got a%h sz%b we%b expected all 0", bus.mem_a, bus.mem_size, bus.mem_we); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.e_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got %b expected 1", bus.e_ready); end
        offer(1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd1);
        step();
        bus.e_valid = 1'b0;
        step();
        n_checks++; if (bus.w_valid !== 1'b1 || bus.w_data !== 32'h55 || bus.w_regwrite !== 1'b1) begin n_fail++; $display("FAIL midrst_first_op: got v%b %h rw%b expected v1 55 rw1", bus.w_valid, bus.w_data, bus.w_regwrite); end
        step();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        we_count     = 0;
        rst          = 1'b0;
        flush        = 1'b0;
        bus.e_valid  = 1'b0;
        bus.e_load   = 1'b0;
        bus.e_store  = 1'b0;
        bus.e_size   = 2'b00;
        bus.e_signed = 1'b0;
        bus.e_addr   = 32'd0;
        bus.e_wdata  = 32'd0;
        bus.e_rd     = 5'd0;
        bus.w_ready  = 1'b1;
        test_reset();
        test_store_load();
        test_fault();
        test_alu();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
